// File: rtl/sysref_gen_pkg.sv
// Shared types and helpers for the PL SYSREF pulse generator.
// Holds the FSM state enum, default widths and the config-legality check.
package sysref_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam int unsigned DEF_CNT_WIDTH   = 16;
   localparam int unsigned DEF_BURST_WIDTH = 8;

   // Legal when period >= 2 and 1 <= high < period.
   function automatic logic cfg_legal(
      input logic [31:0] period,
      input logic [31:0] high
   );
      return (period >= 32'd2) && (high != 32'd0) && (high < period);
   endfunction

endpackage

// File: rtl/sysref_edge_det.sv
// Rising-edge detector on a level already in the clk domain.
// Ports: clk, rst (sync, active high), sig_in level; rise = sig_in & ~previous.
module sysref_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = sig_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/sysref_pulse_gen.sv
// SYSREF-style periodic strobe generator, continuous or N-pulse burst,
// optionally armed on a sync_in rising edge.
// Ports: clk, rst; cfg_period/high/count/use_sync; start, stop, sync_in;
// outputs sysref_out, sysref_edge, busy, done, cfg_err (all registered).
module sysref_pulse_gen
   import sysref_gen_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_WIDTH-1:0]   cfg_period,
   input  logic [CNT_WIDTH-1:0]   cfg_high,
   input  logic [BURST_WIDTH-1:0] cfg_count,
   input  logic                   cfg_use_sync,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   sync_in,
   output logic                   sysref_out,
   output logic                   sysref_edge,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err
);

   localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
   localparam logic [BURST_WIDTH-1:0] BURST_ONE = 1;

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   phase_q, phase_d;
   logic [BURST_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic [CNT_WIDTH-1:0]   high_q, high_d;
   logic [BURST_WIDTH-1:0] count_q, count_d;
   logic                   stop_pend_q, stop_pend_d;
   logic                   sysref_q, sysref_d;
   logic                   edge_q, edge_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic sync_rise;
   logic legal;
   logic last;
   logic burst_end;
   logic run_d;

   sysref_edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sync_in),
      .rise   (sync_rise)
   );

   assign legal = cfg_legal(32'(cfg_period), 32'(cfg_high));

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      pcnt_d      = pcnt_q;
      period_d    = period_q;
      high_d      = high_q;
      count_d     = count_q;
      stop_pend_d = stop_pend_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      last      = (phase_q == (period_q - CNT_ONE));
      // pcnt_q counts completed periods, so this is the count-th one.
      burst_end = (count_q != '0) && (pcnt_q == (count_q - BURST_ONE));

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (legal) begin
                  period_d    = cfg_period;
                  high_d      = cfg_high;
                  count_d     = cfg_count;
                  phase_d     = '0;
                  pcnt_d      = '0;
                  stop_pend_d = 1'b0;
                  state_d     = cfg_use_sync ? ST_ARM : ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ARM: begin
            if (stop) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (sync_rise) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) begin
               stop_pend_d = 1'b0;
               if (burst_end || stop_pend_q || stop) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  phase_d = '0;
                  // Saturate so continuous mode never wraps.
                  if (pcnt_q != '1) begin
                     pcnt_d = pcnt_q + BURST_ONE;
                  end
               end
            end else begin
               phase_d = phase_q + CNT_ONE;
               if (stop) begin
                  stop_pend_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from next-state so they line up with phase.
      run_d    = (state_d == ST_RUN);
      sysref_d = run_d && (phase_d < high_d);
      edge_d   = run_d && (phase_d == '0);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         pcnt_q      <= '0;
         period_q    <= '0;
         high_q      <= '0;
         count_q     <= '0;
         stop_pend_q <= 1'b0;
         sysref_q    <= 1'b0;
         edge_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         pcnt_q      <= pcnt_d;
         period_q    <= period_d;
         high_q      <= high_d;
         count_q     <= count_d;
         stop_pend_q <= stop_pend_d;
         sysref_q    <= sysref_d;
         edge_q      <= edge_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign sysref_out  = sysref_q;
   assign sysref_edge = edge_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_sysref_pulse_gen.sv
// Self-checking bench for sysref_pulse_gen: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_sysref_pulse_gen;

   localparam int CW = 16;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] cfg_period;
   logic [CW-1:0] cfg_high;
   logic [BW-1:0] cfg_count;
   logic          cfg_use_sync;
   logic          start;
   logic          stop;
   logic          sync_in;
   logic          sysref_out;
   logic          sysref_edge;
   logic          busy;
   logic          done;
   logic          cfg_err;

   always #5 clk = ~clk;

   sysref_pulse_gen #(
      .CNT_WIDTH   (CW),
      .BURST_WIDTH (BW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_period   (cfg_period),
      .cfg_high     (cfg_high),
      .cfg_count    (cfg_count),
      .cfg_use_sync (cfg_use_sync),
      .start        (start),
      .stop         (stop),
      .sync_in      (sync_in),
      .sysref_out   (sysref_out),
      .sysref_edge  (sysref_edge),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base   = 0;

   // Trace bits: 4 out, 3 edge, 2 busy, 1 done, 0 err.
   logic [4:0] tr [0:63];

   // Model: mode 0 idle, 1 waiting for sync, 2 running since m_rs.
   int   m_mode = 0;
   int   m_p = 2, m_h = 1, m_n = 0, m_rs = 0;
   bit   m_stop = 0;
   bit   m_prev = 0;
   logic [4:0] exp_v = '0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] rng(int lo, int hi);
      logic [63:0] r;
      r = '0;
      for (int i = lo; i <= hi; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] col(int b, int n);
      logic [63:0] r;
      r = '0;
      for (int i = 1; i <= n; i++) r[i] = tr[i][b];
      return r;
   endfunction

   // Model step plus per-cycle compare.
   always @(posedge clk) begin
      int  c;
      int  k;
      int  ph;
      bit  rise;
      bit  d_e;
      bit  e_e;
      logic [4:0] got;
      c   = cyc;
      d_e = 0;
      e_e = 0;
      if (rst) begin
         m_mode = 0;
         m_stop = 0;
         m_prev = 0;
         exp_v  = '0;
      end else begin
         rise   = sync_in && !m_prev;
         m_prev = sync_in;
         case (m_mode)
            0: if (start) begin
               if (cfg_period >= 2 && cfg_high >= 1 && cfg_high < cfg_period) begin
                  m_p    = int'(cfg_period);
                  m_h    = int'(cfg_high);
                  m_n    = int'(cfg_count);
                  m_stop = 0;
                  if (cfg_use_sync) m_mode = 1;
                  else begin
                     m_mode = 2;
                     m_rs   = c + 1;
                  end
               end else begin
                  e_e = 1;
               end
            end
            1: if (stop) begin
               m_mode = 0;
               d_e    = 1;
            end else if (rise) begin
               m_mode = 2;
               m_rs   = c + 1;
            end
            default: begin
               k = c - m_rs;
               if (stop) m_stop = 1;
               if (k % m_p == m_p - 1) begin
                  if ((m_n != 0 && k / m_p + 1 == m_n) || m_stop) begin
                     m_mode = 0;
                     d_e    = 1;
                  end
                  m_stop = 0;
               end
            end
         endcase
         ph = (m_mode == 2) ? (c + 1 - m_rs) % m_p : 0;
         exp_v = {m_mode == 2 && ph < m_h, m_mode == 2 && ph == 0,
                  m_mode != 0, d_e, e_e};
      end
      #1;
      got = {sysref_out, sysref_edge, busy, done, cfg_err};
      chk($sformatf("outputs@%0d", c + 1), 64'(got), 64'(exp_v));
      if (c + 1 - base >= 0 && c + 1 - base < 64) tr[c + 1 - base] = got;
      cyc++;
   end

   task automatic goto(int k);
      while (cyc < base + k) @(negedge clk);
   endtask

   task automatic begin_scn(int p, int h, int n, bit us);
      @(negedge clk);
      for (int i = 0; i < 64; i++) tr[i] = '0;
      base         = cyc;
      cfg_period   = CW'(p);
      cfg_high     = CW'(h);
      cfg_count    = BW'(n);
      cfg_use_sync = us;
      start        = 1'b1;
      goto(1);
      start        = 1'b0;
      // Scramble config to show it was latched.
      cfg_period   = CW'(3);
      cfg_high     = CW'(1);
      cfg_count    = BW'(7);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; sync_in = 1'b0;
      cfg_period = '0; cfg_high = '0; cfg_count = '0; cfg_use_sync = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({sysref_out, sysref_edge, busy, done, cfg_err}), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Burst of two periods.
      begin_scn(10, 3, 2, 0);
      goto(25);
      chk("t1_out",  col(4, 25), rng(1, 3) | rng(11, 13));
      chk("t1_edge", col(3, 25), rng(1, 1) | rng(11, 11));
      chk("t1_busy", col(2, 25), rng(1, 20));
      chk("t1_done", col(1, 25), rng(21, 21));

      // Continuous with a graceful stop.
      begin_scn(4, 1, 0, 0);
      goto(9);  stop = 1'b1;
      goto(10); stop = 1'b0;
      goto(16);
      chk("t2_out",  col(4, 16), rng(1, 1) | rng(5, 5) | rng(9, 9));
      chk("t2_busy", col(2, 16), rng(1, 12));
      chk("t2_done", col(1, 16), rng(13, 13));

      // Sync-armed single pulse.
      begin_scn(8, 2, 1, 1);
      goto(7);  sync_in = 1'b1;
      goto(20);
      sync_in = 1'b0;
      chk("t3_busy", col(2, 20), rng(1, 15));
      chk("t3_out",  col(4, 20), rng(8, 9));
      chk("t3_edge", col(3, 20), rng(8, 8));
      chk("t3_done", col(1, 20), rng(16, 16));

      // Illegal configs.
      begin_scn(1, 5, 1, 0);
      goto(4);
      chk("t4a_err", col(0, 4), rng(1, 1));
      chk("t4a_busy_out", col(2, 4) | col(4, 4), 64'(0));
      begin_scn(5, 5, 1, 0);
      goto(4);
      chk("t4b_err", col(0, 4), rng(1, 1));
      chk("t4b_busy_out", col(2, 4) | col(4, 4), 64'(0));
      begin_scn(5, 0, 1, 0);
      goto(4);
      chk("t4c_err", col(0, 4), rng(1, 1));
      chk("t4c_busy_out", col(2, 4) | col(4, 4), 64'(0));

      // Abort while armed.
      begin_scn(8, 2, 1, 1);
      goto(3); stop = 1'b1;
      goto(4); stop = 1'b0;
      goto(8);
      chk("t5_done", col(1, 8), rng(4, 4));
      chk("t5_busy", col(2, 8), rng(1, 3));
      chk("t5_out",  col(4, 8), 64'(0));

      // Reset mid-run, then restart.
      begin_scn(10, 3, 0, 0);
      cfg_period = CW'(10); cfg_high = CW'(3); cfg_count = '0;
      goto(5); rst = 1'b1;
      goto(6); rst = 1'b0;
      goto(8); start = 1'b1;
      goto(9); start = 1'b0;
      goto(12);
      chk("t6_out",  col(4, 12), rng(1, 3) | rng(9, 11));
      chk("t6_busy", col(2, 12), rng(1, 5) | rng(9, 12));
      chk("t6_done", col(1, 12), 64'(0));
      stop = 1'b1;
      goto(13); stop = 1'b0;
      goto(30);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         cfg_period   = CW'($urandom_range(0, 12));
         cfg_high     = CW'($urandom_range(0, 12));
         cfg_count    = BW'($urandom_range(0, 3));
         cfg_use_sync = 1'($urandom_range(0, 1));
         start        = ($urandom_range(0, 3) == 0);
         stop         = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 5) == 0) sync_in = ~sync_in;
         rst          = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysref_pulse_gen.md
Name: sysref_pulse_gen

Overview:
- Generates SYSREF-style periodic strobes in the PL fabric: the transmit end of the PL SYSREF path, complementing the receive side that buffers the board's pl_sysref into the system block.
- Used to drive multi-tile-sync and DDC/DUC phase-reset logic, and to loop back into the converter sysref input during bring-up.
- Runs in continuous or N-pulse burst mode. A burst can optionally be armed to start on the rising edge of an externally received sync strobe.

Parameters:
- CNT_WIDTH, 16: width of the period and high-time counters.
- BURST_WIDTH, 8: width of the burst-count config and counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_period  in  CNT_WIDTH  period in clk cycles; legal range ≥2.
- cfg_high  in  CNT_WIDTH  high time in clk cycles; legal range 1..cfg_period-1.
- cfg_count  in  BURST_WIDTH  pulses per burst; 0 = continuous.
- cfg_use_sync  in  1  1 = wait for a rising edge of sync_in before the first pulse.
- start  in  1  level, sampled each cycle; accepted only in IDLE.
- stop  in  1  level, sampled each cycle; requests graceful end.
- sync_in  in  1  received sync level (already in the clk domain).
- sysref_out  out  1  generated strobe.
- sysref_edge  out  1  one-cycle marker coincident with each first high cycle of sysref_out.
- busy  out  1  high in ARM or RUN.
- done  out  1  one-cycle pulse at end of burst, stop or abort.
- cfg_err  out  1  one-cycle pulse when start is rejected for illegal config.

Behaviour:
- All outputs are registered. Reset value of every output and of all state is 0 (state IDLE).
- rst asserted mid-operation: the cycle after rst is sampled high, all outputs are 0 and state is IDLE. No done pulse.
- States and transitions:
  - IDLE: start=1 with legal config latches cfg_* into internal registers; next state is RUN if cfg_use_sync=0, else ARM.
  - IDLE: start=1 with illegal config (period<2, high=0, or high≥period) pulses cfg_err next cycle and stays IDLE.
  - IDLE: stop is ignored.
  - ARM: busy=1, sysref_out=0. A sync_in rising edge moves to RUN.
    - Edge detection uses a sync_prev register updated every cycle in every state.
    - A rising edge is sync_in=1 and sync_prev=0 in the same cycle.
  - ARM: stop=1 gives IDLE next cycle with done=1 (abort). If stop and a sync edge coincide, stop wins.
  - RUN: phase counter runs 0..period-1 then wraps to 0. sysref_out=1 while phase<high. sysref_edge=1 when phase=0.
  - RUN: pulse counter increments on each wrap.
  - RUN: at the final cycle of a period (phase=period-1), go to IDLE with done=1 and busy=0 on the next cycle if either:
    - cfg_count≠0 and this is the cfg_count-th period, or
    - a stop has been registered during this period.
  - Stop is never truncating: a stop seen at any phase is latched (stop_pend) and honoured at the period end.
- Latency: start sampled at cycle c with sync disabled gives RUN at c+1, with sysref_out=1 and sysref_edge=1 at c+1. A sync edge at cycle s gives the first high cycle at s+1.
- start while busy is ignored. Config inputs changing while busy have no effect.
- Counters are unsigned. The pulse counter saturates in continuous mode and never wraps to a false match.
- cfg_count=1 produces exactly one period.

Decomposition:
- Shared package sysref_gen_pkg holds:
  - the state enum (IDLE, ARM, RUN);
  - default widths;
  - the config-legality function.
- One natural sub-module: sysref_edge_det, a registered rising-edge detector on sync_in, reusable by the receive path.
- Remainder is a single FSM plus counters.

Test Plan:
- period=10, high=3, count=2, use_sync=0, start pulse at cycle 0 -> sysref_out high cycles 1-3 and 11-13; sysref_edge at 1 and 11; busy 1..20; done at cycle 21 only.
- period=4, high=1, count=0, start at 0, stop held at cycle 9 -> pulses at cycles 1, 5, 9; the period ending at cycle 12 completes; done at 13; no pulse at 13.
- use_sync=1, period=8, high=2, count=1, start at 0, sync_in rises at cycle 7 -> busy from 1; sysref_out high at cycles 8-9; done at 16.
- Illegal configs at start: period=1, high=5/period=5, and high=0 -> cfg_err one cycle after each start; busy stays 0; sysref_out stays 0.
- ARM abort: use_sync=1, start at 0, stop at 3 with no sync edge -> done at 4, busy 0 at 4, no sysref_out pulse.
- rst at cycle 5 during RUN (period=10, high=3) -> every output 0 from cycle 6; no done. A new start at cycle 8 gives a pulse at cycle 9.
